// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_seq_state_e;

  function automatic int cnt_width(input int min_assert, input int gap);
    int m;
    m = (min_assert > gap) ? min_assert : gap;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic bit params_legal(input int stages, input int channels,
                                      input int min_assert, input int gap);
    return (stages >= 2) && (channels >= 1) && (min_assert >= 1) && (gap >= 1);
  endfunction

endpackage

// File: rtl/rst_deassert_sync.sv
// Reset deassertion synchroniser: clears asynchronously, shifts in 1 per edge.
// Output is the last flop of a STAGES-deep chain.
module rst_deassert_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], 1'b1};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async assert, synchronised deassert, then per-channel
// release in index order with a fixed gap; software request restarts it.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int CHANNELS   = 3,
  parameter int MIN_ASSERT = 4,
  parameter int GAP        = 3
) (
  input  logic                RSTSEQ_CLK,
  input  logic                RSTSEQ_RST,
  input  logic                RSTSEQ_SW_RST,
  output logic [CHANNELS-1:0] RSTSEQ_OUT,
  output logic                RSTSEQ_DONE
);

  localparam int CNT_W = cnt_width(MIN_ASSERT, GAP);
  localparam int IDX_W = idx_width(CHANNELS);

  if (!params_legal(STAGES, CHANNELS, MIN_ASSERT, GAP)) begin : g_bad_params
    $error("rst_seq_ctrl: illegal STAGES/CHANNELS/MIN_ASSERT/GAP");
  end

  rst_seq_state_e      r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [CHANNELS-1:0] r_out;
  logic                r_done;
  logic                w_sync;
  logic [CHANNELS-1:0] w_idx_onehot;

  rst_deassert_sync #(.STAGES(STAGES)) u_sync (
    .i_clk   (RSTSEQ_CLK),
    .i_rst_n (RSTSEQ_RST),
    .o_sync  (w_sync)
  );

  assign w_idx_onehot = CHANNELS'(1) << r_idx;

  // The sync-exit edge is the first hold count (counter is still 0 in SYNC),
  // so MIN_ASSERT == 1 releases channel 0 straight out of SYNC.
  always_ff @(posedge RSTSEQ_CLK or negedge RSTSEQ_RST) begin
    if (!RSTSEQ_RST) begin
      r_state <= SYNC;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else if (RSTSEQ_SW_RST && (r_state != SYNC)) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        SYNC, HOLD: begin
          if ((r_state == HOLD) || w_sync) begin
            if (r_cnt == CNT_W'(MIN_ASSERT - 1)) begin
              r_out[0] <= 1'b1;
              r_cnt    <= '0;
              if (CHANNELS == 1) begin
                r_state <= RUN;
                r_done  <= 1'b1;
              end else begin
                r_state <= RELEASE;
                r_idx   <= IDX_W'(1);
              end
            end else begin
              r_state <= HOLD;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (r_cnt == CNT_W'(GAP - 1)) begin
            r_out <= r_out | w_idx_onehot;
            r_cnt <= '0;
            if (r_idx == IDX_W'(CHANNELS - 1)) begin
              r_state <= RUN;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          r_cnt <= '0;
        end
        default: begin
          r_state <= SYNC;
        end
      endcase
    end
  end

  assign RSTSEQ_OUT  = r_out;
  assign RSTSEQ_DONE = r_done;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default configuration plus the
// CHANNELS=1/MIN_ASSERT=1/GAP=1/STAGES=3 boundary configuration.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sw_rst;
  logic [2:0] out_a;
  logic       done_a;
  logic [0:0] out_b;
  logic       done_b;

  int n_cmp;
  int n_fail;

  rst_seq_ctrl #(.STAGES(2), .CHANNELS(3), .MIN_ASSERT(4), .GAP(3)) dut_a (
    .RSTSEQ_CLK    (clk),
    .RSTSEQ_RST    (rst_n),
    .RSTSEQ_SW_RST (sw_rst),
    .RSTSEQ_OUT    (out_a),
    .RSTSEQ_DONE   (done_a)
  );

  rst_seq_ctrl #(.STAGES(3), .CHANNELS(1), .MIN_ASSERT(1), .GAP(1)) dut_b (
    .RSTSEQ_CLK    (clk),
    .RSTSEQ_RST    (rst_n),
    .RSTSEQ_SW_RST (sw_rst),
    .RSTSEQ_OUT    (out_b),
    .RSTSEQ_DONE   (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Default-config pattern k edges after a software trigger edge.
  function automatic logic [2:0] sw_pat(input int k);
    return {k >= 10, k >= 7, k >= 4};
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    sw_rst = 1'b0;

    #2;
    check("reset_out_a", {5'd0, out_a}, 8'h00);
    check("reset_done_a", {7'd0, done_a}, 8'h00);
    check("reset_out_b", {7'd0, out_b}, 8'h00);
    tick();
    tick();
    check("reset_held_out_a", {5'd0, out_a}, 8'h00);

    // Power-up: 001 @6, 011 @9, 111 @12; boundary instance releases @4.
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("pwr_out_a_e%0d", k), {5'd0, out_a},
            {5'd0, (k >= 12), (k >= 9), (k >= 6)});
      check($sformatf("pwr_done_a_e%0d", k), {7'd0, done_a}, {7'd0, (k >= 12)});
      check($sformatf("pwr_out_b_e%0d", k), {7'd0, out_b}, {7'd0, (k >= 4)});
      check($sformatf("pwr_done_b_e%0d", k), {7'd0, done_b}, {7'd0, (k >= 4)});
    end

    // Asynchronous assertion with no clock edge.
    rst_n = 1'b0;
    #1;
    check("async_out_a", {5'd0, out_a}, 8'h00);
    check("async_done_a", {7'd0, done_a}, 8'h00);
    check("async_out_b", {7'd0, out_b}, 8'h00);
    check("async_done_b", {7'd0, done_b}, 8'h00);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    check("rerun_out_a", {5'd0, out_a}, 8'h07);
    check("rerun_done_a", {7'd0, done_a}, 8'h01);

    // Software reset ignored effects check: one-cycle request in RUN.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("sw_run_out_a_e0", {5'd0, out_a}, 8'h00);
    check("sw_run_done_a_e0", {7'd0, done_a}, 8'h00);
    check("sw_run_out_b_e0", {7'd0, out_b}, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("sw_run_out_a_e%0d", k), {5'd0, out_a}, {5'd0, sw_pat(k)});
      check($sformatf("sw_run_out_b_e%0d", k), {7'd0, out_b}, 8'h01);
    end

    // Mid-release restart: out_a is 011 here, sample request at next edge.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("sw_mid_out_a_e0", {5'd0, out_a}, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("sw_mid_out_a_e%0d", k), {5'd0, out_a}, {5'd0, sw_pat(k)});
      check($sformatf("sw_mid_done_a_e%0d", k), {7'd0, done_a}, {7'd0, (k >= 10)});
    end

    // Held request: five sampled-high edges, timing restarts from the last.
    sw_rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("sw_hold_out_a_s%0d", k), {5'd0, out_a}, 8'h00);
      check($sformatf("sw_hold_out_b_s%0d", k), {7'd0, out_b}, 8'h00);
    end
    sw_rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("sw_hold_out_a_e%0d", k), {5'd0, out_a}, {5'd0, sw_pat(k)});
    end
    check("sw_hold_done_a", {7'd0, done_a}, 8'h01);
    check("sw_hold_done_b", {7'd0, done_b}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
